popcnt_accum: RTL and testbench
===============================

# popcnt_accum

Parametrised successor to the 8-bit switch counter. On each start request it snapshots an N-bit switch vector and counts its set bits serially, one bit per clock. It then adds the count to a saturating accumulator, plus a one-count bonus when the count exceeds a threshold. It sits between the board switch/key inputs and the LED display logic, and gives the display a busy/done handshake, a threshold event and a sticky saturation flag.

## Interface
- N, default 10: switch vector width; N >= 1.
- ACC_W, default 10: accumulator width.
- THRESH, default 3: event threshold; event fires when popcount > THRESH; 0 <= THRESH < N.
- CW (localparam) = $clog2(N+1): popcount width.

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; all registers are cleared while it is low.
- sw  in  N  switch vector; sampled only at start.
- key  in  2  active-high; key[0] = start (rising edge), key[1] = synchronous clear.
- ledr  out  ACC_W  accumulator value.
- rez  out  CW  popcount of the most recently completed snapshot.
- event  out  1  high when the last completed popcount > THRESH.
- busy  out  1  high while a count is in progress (state != IDLE).
- done  out  1  one-cycle pulse when ledr/rez/event update.
- sat  out  1  sticky; set when an addition clips at 2^ACC_W-1.

## Operation
- Reset values (reset low): ledr=0, rez=0, event=0, busy=0, done=0, sat=0, state=IDLE, key0_q=0, internal counters=0.
- Start edge detection: key0_q registers key[0] every cycle. A start occurs when key[0]=1 and key0_q=0.
- FSM states:
  - IDLE: on a start, snap<=sw, idx<=0, cnt<=0, go to SCAN.
  - SCAN: cnt<=cnt+snap[idx] and idx<=idx+1. After processing idx=N-1, go to ADD.
  - ADD: compute bonus=(cnt>THRESH), sum=ledr+cnt+bonus at ACC_W+CW+1 bits.
    - ledr<=min(sum, 2^ACC_W-1).
    - sat<=sat | (sum > 2^ACC_W-1).
    - rez<=cnt, event<=bonus, done<=1, go to IDLE.
- done is 0 in every cycle except the one following the ADD edge.
- Clear (key[1]=1): top priority over everything except reset.
  - ledr, rez, event, sat and done go to 0.
  - state goes to IDLE, aborting any scan.
  - key0_q still updates normally.
- Boundary behaviour:
  - A start while busy is ignored, not queued.
  - A start in the same cycle as clear is ignored. A held key[0] does not retrigger after clear.
  - sw changes during SCAN do not affect the result (snapshot).
  - Once saturated, ledr stays at 2^ACC_W-1 until clear or reset; sat stays high.
  - Reset mid-scan: immediate return to reset values; no done pulse.

## Timing
- Start sampled at edge E0: busy=1 from E0.
- SCAN occupies edges E1..EN; ADD outputs update at edge E(N+1).
- At E(N+1): busy=0 and done=1 for exactly one cycle, coincident with the new ledr/rez/event.
- Latency from start-sampling edge to result is N+1 cycles; 11 for the default.
- Minimum start-to-start spacing is N+2 cycles, including the key[0] low cycle needed to re-arm edge detection.
- Clear takes effect at the next edge. Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset low for 3 cycles with random sw/key → all outputs 0. Release → outputs stay 0 with keys low.
- sw=10'b0000000111, one key[0] pulse:
  - busy high for 11 cycles.
  - Then ledr=3, rez=3, event=0, done high for exactly 1 cycle.
- Next, sw=10'h3FF, one key[0] pulse → ledr=14 (3+10+1), rez=10, event=1. Toggle sw during the scan → result unchanged.
- Instance with ACC_W=6, sw all ones, six starts → ledr after each: 11, 22, 33, 44, 55, 63. sat=1 after the sixth, stays 1 on a seventh start.
- Start, then key[1]=1 on the 4th busy cycle → next cycle busy=0, ledr=0, sat=0, no done pulse ever. Holding key[0] high through the clear starts nothing.
- Second key[0] pulse during busy → ignored, exactly one done. Start and clear in the same cycle → no scan, all outputs 0.

Source files
------------

// File: rtl/popcnt_accum.sv
// popcnt_accum: snapshots an N-bit switch vector on a start edge, counts its
// set bits serially (one bit per clock) and folds the count, plus a bonus of
// one when the count exceeds THRESH, into a saturating accumulator.
//
// Handshake (valid/ready view): a start is offered by a rising edge on key[0];
// it is accepted only when busy is low and key[1] is low in the same cycle,
// otherwise it is dropped, never queued. busy stays high from the accepting
// edge until the result edge, where done pulses high for exactly one cycle
// together with the new ledr/rez/thr_event values.
//
// The threshold flag is named thr_event because 'event' is a reserved word.
module popcnt_accum #(
  parameter int N      = 10,
  parameter int ACC_W  = 10,
  parameter int THRESH = 3,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     sw,
  input  logic [1:0]       key,
  output logic [ACC_W-1:0] ledr,
  output logic [CW-1:0]    rez,
  output logic             thr_event,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic [1:0]       state_dbg
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = ACC_W + CW + 1;
  localparam logic [SW-1:0] ACC_MAX = {{(CW + 1){1'b0}}, {ACC_W{1'b1}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ADD  = 2'd2
  } state_t;

  state_t        state;
  logic          key0_q;
  logic [N-1:0]  snap;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          start;
  logic          bonus;
  logic [SW-1:0] sum;
  logic          clip;

  assign start     = key[0] & ~key0_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Accumulation arithmetic for the ADD step, wide enough that it never wraps.
  always_comb begin
    bonus = 1'b0;
    sum   = '0;
    clip  = 1'b0;
    bonus = (cnt > CW'(THRESH));
    sum   = SW'(ledr) + SW'(cnt) + SW'(bonus);
    clip  = (sum > ACC_MAX);
  end

  // Control FSM, bit counter and registered outputs; clear overrides all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      key0_q    <= 1'b0;
      snap      <= '0;
      idx       <= '0;
      cnt       <= '0;
      ledr      <= '0;
      rez       <= '0;
      thr_event <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      key0_q <= key[0];
      done   <= 1'b0;
      if (key[1]) begin
        state     <= IDLE;
        idx       <= '0;
        cnt       <= '0;
        ledr      <= '0;
        rez       <= '0;
        thr_event <= 1'b0;
        sat       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              snap  <= sw;
              idx   <= '0;
              cnt   <= '0;
              state <= SCAN;
            end
          end
          SCAN: begin
            cnt <= cnt + CW'(snap[idx]);
            idx <= idx + IW'(1);
            if (idx == LAST_IDX) begin
              state <= ADD;
            end
          end
          ADD: begin
            ledr      <= clip ? ACC_MAX[ACC_W-1:0] : sum[ACC_W-1:0];
            sat       <= sat | clip;
            rez       <= cnt;
            thr_event <= bonus;
            done      <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_popcnt_accum.sv
// Bench for popcnt_accum: two instances share clock and inputs, the default
// one (ACC_W=10) and a narrow one (ACC_W=6) that saturates quickly.
module tb_popcnt_accum;

  logic       clk;
  logic       reset;
  logic [9:0] sw;
  logic [1:0] key;

  logic [9:0] a_ledr;
  logic [3:0] a_rez;
  logic       a_evt, a_busy, a_done, a_sat;
  logic [1:0] a_state;
  logic [5:0] b_ledr;
  logic [3:0] b_rez;
  logic       b_evt, b_busy, b_done, b_sat;
  logic [1:0] b_state;

  int total = 0;
  int bad   = 0;

  // reference model: accumulator values for both widths
  int m_a, m_b, m_rez;
  bit m_evt, m_sa, m_sb;

  popcnt_accum #(.N(10), .ACC_W(10), .THRESH(3)) dut_a (
    .clk(clk), .reset(reset), .sw(sw), .key(key),
    .ledr(a_ledr), .rez(a_rez), .thr_event(a_evt), .busy(a_busy),
    .done(a_done), .sat(a_sat), .state_dbg(a_state)
  );

  popcnt_accum #(.N(10), .ACC_W(6), .THRESH(3)) dut_b (
    .clk(clk), .reset(reset), .sw(sw), .key(key),
    .ledr(b_ledr), .rez(b_rez), .thr_event(b_evt), .busy(b_busy),
    .done(b_done), .sat(b_sat), .state_dbg(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_rez = 0; m_evt = 0; m_sa = 0; m_sb = 0;
  endfunction

  function automatic void model_apply(input logic [9:0] v);
    int pc, s;
    pc = $countones(v);
    m_rez = pc;
    m_evt = (pc > 3);
    s = m_a + pc + (pc > 3 ? 1 : 0);
    if (s > 1023) begin m_a = 1023; m_sa = 1; end else m_a = s;
    s = m_b + pc + (pc > 3 ? 1 : 0);
    if (s > 63) begin m_b = 63; m_sb = 1; end else m_b = s;
  endfunction

  // driver: one start pulse, then wait (bounded) for done; returns at the done cycle
  task automatic start_and_wait(input logic [9:0] v, input bit toggle,
                                output int bc, output bit seen);
    sw = v; key = 2'b01;
    @(negedge clk);
    key = 2'b00;
    bc = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_done) begin
        seen = 1;
        break;
      end
      if (a_busy) bc++;
      if (toggle) sw = 10'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_clear();
    key = 2'b10;
    @(negedge clk);
    key = 2'b00;
    model_reset();
  endtask

  task automatic check_result(input string name, input int bc, input bit seen);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL %s done_timeout got=%0b want=1", name, seen); end
    total++; if (bc != 11) begin bad++; $display("FAIL %s busy_cycles got=%0d want=11", name, bc); end
    total++; if (a_ledr !== 10'(m_a)) begin bad++; $display("FAIL %s ledr got=%0d want=%0d", name, a_ledr, m_a); end
    total++; if (a_rez !== 4'(m_rez)) begin bad++; $display("FAIL %s rez got=%0d want=%0d", name, a_rez, m_rez); end
    total++; if (a_evt !== m_evt) begin bad++; $display("FAIL %s event got=%0b want=%0b", name, a_evt, m_evt); end
    total++; if (a_sat !== m_sa) begin bad++; $display("FAIL %s sat got=%0b want=%0b", name, a_sat, m_sa); end
    total++; if (b_ledr !== 6'(m_b)) begin bad++; $display("FAIL %s ledr6 got=%0d want=%0d", name, b_ledr, m_b); end
    total++; if (b_sat !== m_sb) begin bad++; $display("FAIL %s sat6 got=%0b want=%0b", name, b_sat, m_sb); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      sw = 10'($urandom); key = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    total++; if ({a_ledr, a_rez, a_evt, a_busy, a_done, a_sat} !== '0) begin bad++;
      $display("FAIL reset_hold a got=%h want=0", {a_ledr, a_rez, a_evt, a_busy, a_done, a_sat}); end
    total++; if ({b_ledr, b_rez, b_evt, b_busy, b_done, b_sat} !== '0) begin bad++;
      $display("FAIL reset_hold b got=%h want=0", {b_ledr, b_rez, b_evt, b_busy, b_done, b_sat}); end
    key = 2'b00; reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({a_ledr, a_rez, a_evt, a_busy, a_done, a_sat} !== '0) begin bad++;
      $display("FAIL reset_release got=%h want=0", {a_ledr, a_rez, a_evt, a_busy, a_done, a_sat}); end
    model_reset();
  endtask

  task automatic test_basic();
    int bc; bit seen;
    start_and_wait(10'b0000000111, 0, bc, seen);
    model_apply(10'b0000000111);
    check_result("basic", bc, seen);
    total++; if (a_ledr !== 10'd3) begin bad++; $display("FAIL basic_const ledr got=%0d want=3", a_ledr); end
    @(negedge clk);
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%0b want=0", a_done); end
  endtask

  task automatic test_all_ones_toggle();
    int bc; bit seen;
    start_and_wait(10'h3FF, 1, bc, seen);
    model_apply(10'h3FF);
    check_result("all_ones", bc, seen);
    total++; if (a_ledr !== 10'd14) begin bad++; $display("FAIL all_ones_const ledr got=%0d want=14", a_ledr); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int bc; bit seen; logic [9:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 10'($urandom);
      start_and_wait(v, k[0], bc, seen);
      model_apply(v);
      check_result("random", bc, seen);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // starts at the minimum spacing: next key[0] rise offered right at the done cycle
  task automatic test_back_to_back();
    int bc; bit seen; logic [9:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 10'($urandom);
      start_and_wait(v, 0, bc, seen);
      model_apply(v);
      check_result("back_to_back", bc, seen);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int bc; bit seen;
    int exp_b[7] = '{11, 22, 33, 44, 55, 63, 63};
    do_clear();
    for (int k = 0; k < 7; k++) begin
      start_and_wait(10'h3FF, 0, bc, seen);
      model_apply(10'h3FF);
      check_result("saturation", bc, seen);
      total++; if (b_ledr !== 6'(exp_b[k])) begin bad++; $display("FAIL sat_table[%0d] ledr6 got=%0d want=%0d", k, b_ledr, exp_b[k]); end
      total++; if (b_sat !== (k >= 5)) begin bad++; $display("FAIL sat_table[%0d] sat6 got=%0b want=%0b", k, b_sat, (k >= 5)); end
      @(negedge clk);
    end
  endtask

  task automatic test_clear_abort();
    int bc, dn, bz;
    sw = 10'($urandom); key = 2'b01; bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_busy) bc++;
      if (bc == 4) break;
    end
    key = 2'b11;
    @(negedge clk);
    model_reset();
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL clear_abort busy got=%0b want=0", a_busy); end
    total++; if (a_ledr !== 10'd0) begin bad++; $display("FAIL clear_abort ledr got=%0d want=0", a_ledr); end
    total++; if ({a_sat, b_sat} !== 2'b00) begin bad++; $display("FAIL clear_abort sat got=%b want=00", {a_sat, b_sat}); end
    total++; if ({a_rez, a_evt, b_ledr} !== '0) begin bad++; $display("FAIL clear_abort others got=%h want=0", {a_rez, a_evt, b_ledr}); end
    key = 2'b01; dn = 0; bz = 0;
    repeat (20) begin
      @(negedge clk);
      dn += int'(a_done | b_done); bz += int'(a_busy | b_busy);
    end
    total++; if (dn != 0) begin bad++; $display("FAIL clear_abort done_pulses got=%0d want=0", dn); end
    total++; if (bz != 0) begin bad++; $display("FAIL clear_abort held_key_busy got=%0d want=0", bz); end
    key = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int dn; logic [9:0] v; logic [9:0] cap;
    v = 10'($urandom) | 10'h001;
    sw = v; key = 2'b01;
    @(negedge clk); key = 2'b00;
    repeat (2) @(negedge clk);
    key = 2'b01; sw = ~v;
    @(negedge clk); key = 2'b00;
    model_apply(v);
    dn = 0; cap = '0;
    repeat (30) begin
      @(negedge clk);
      if (a_done) begin dn++; cap = a_ledr; end
    end
    total++; if (dn != 1) begin bad++; $display("FAIL busy_ignore done_count got=%0d want=1", dn); end
    total++; if (cap !== 10'(m_a)) begin bad++; $display("FAIL busy_ignore ledr got=%0d want=%0d", cap, m_a); end
  endtask

  task automatic test_start_with_clear();
    int dn, bz;
    sw = 10'($urandom); key = 2'b11;
    @(negedge clk); key = 2'b00;
    model_reset();
    dn = 0; bz = 0;
    repeat (15) begin
      @(negedge clk);
      dn += int'(a_done); bz += int'(a_busy);
    end
    total++; if (bz != 0) begin bad++; $display("FAIL start_clear busy got=%0d want=0", bz); end
    total++; if (dn != 0) begin bad++; $display("FAIL start_clear done got=%0d want=0", dn); end
    total++; if ({a_ledr, a_rez, a_evt, a_sat} !== '0) begin bad++;
      $display("FAIL start_clear outputs got=%h want=0", {a_ledr, a_rez, a_evt, a_sat}); end
  endtask

  initial begin
    reset = 1'b0; sw = '0; key = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_all_ones_toggle();
    test_random();
    test_back_to_back();
    test_saturation();
    test_clear_abort();
    test_busy_ignore();
    test_start_with_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
